// File: rtl/instr_encoder_if.sv
// Request/instruction-memory bundle between a producer and instr_encoder.
// Latency: none, wiring only.
// Backpressure: in_ready from the encoder gates request acceptance.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  // Producer side: drives requests, observes the memory write port and status.
  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, target,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );

  // Encoder side.
  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, target,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS-style instruction descriptions and writes them sequentially into instruction memory.
// Latency: accept at edge N, imem_we high in the cycle after edge N; one word per 2 cycles at best.
// Backpressure: in_ready low while writing, when full, or during clear; illegal ops only set err.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  instr_encoder_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;

  // Combinational instruction encoding; op_sel 10-15 are flagged illegal.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (bus.op_sel)
      4'd0:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h00, 6'h20};
      4'd1:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h00, 6'h22};
      4'd2:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h00, 6'h24};
      4'd3:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h00, 6'h25};
      4'd4:    enc_word = {6'h00, bus.rs, bus.rt, bus.rd, 5'h00, 6'h2A};
      4'd5:    enc_word = {6'h23, bus.rs, bus.rt, bus.imm};
      4'd6:    enc_word = {6'h2B, bus.rs, bus.rt, bus.imm};
      4'd7:    enc_word = {6'h04, bus.rs, bus.rt, bus.imm};
      4'd8:    enc_word = {6'h08, bus.rs, bus.rt, bus.imm};
      4'd9:    enc_word = {6'h02, bus.target};
      default: enc_legal = 1'b0;
    endcase
  end

  assign bus.in_ready   = (state_q == IDLE) & ~full_q & ~clear;
  assign accept         = bus.in_valid & bus.in_ready;
  // A clear or reset landing on the write cycle drops the pending write.
  assign bus.imem_we    = (state_q == WRITE) & ~clear & ~reset;
  assign bus.imem_addr  = wr_ptr_q;
  assign bus.imem_wdata = word_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.err        = err_q;

  // Next-state logic: clear restarts everything, otherwise accept -> WRITE -> IDLE.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    err_d    = err_q;
    word_d   = word_q;
    if (clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (enc_legal) begin
              word_d  = enc_word;
              state_d = WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WRITE: begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (&wr_ptr_q) begin
            full_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      word_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      err_q    <= err_d;
      word_q   <= word_d;
    end
  end

endmodule
